// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
//
// Write-side producer for the 32-entry register file. Merges the single-cycle
// ALU result path and the variable-latency memory/load path onto the one
// register-file write port (AD3/WE3/WD3). The ALU path has priority; memory
// results wait in a small FIFO. A starvation counter raises alu_stall so a
// waiting memory result is forced out. An optional query port reports whether
// a write to a given register is still pending.
//
// Optional feature macro: WB_PENDING_QUERY_EN
//   defined   - qry_hit compares qry_addr against every valid FIFO entry and
//               the staged write.
//   undefined - no comparators, qry_hit tied to 0, qry_addr ignored.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   alu_valid/rd/data   ALU result for this cycle
//   mem_valid/rd/data   memory result offer; mem_ready = FIFO not full
//   alu_stall           registered; upstream must not assert alu_valid while high
//   AD3, WE3, WD3       registered register-file write port
//   qry_addr, qry_hit   pending-write hazard query (combinational)
// -----------------------------------------------------------------------------
module regfile_writeback #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [ADDRESS_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     alu_stall,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic                     WE3,
  output logic [DATA_WIDTH-1:0]    WD3,
  input  logic [ADDRESS_WIDTH-1:0] qry_addr,
  output logic                     qry_hit
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [ADDRESS_WIDTH-1:0] fifo_rd   [DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data [DEPTH];

  // Pointers carry one wrap bit above the index so full and empty differ.
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_next;
  logic             empty, full, full_next;
  logic             push, pop, alu_take;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_idx == rd_idx);

  assign mem_ready = ~full;

  // A memory result aimed at x0 completes its handshake but is not stored.
  assign push = mem_valid && mem_ready && (mem_rd != '0);

  // An ALU result aimed at x0 is consumed without taking the write port, so
  // it never blocks a pop. While stalled, any ALU result is dropped.
  assign alu_take = ~alu_stall && alu_valid && (alu_rd != '0);
  assign pop      = ~alu_take && ~empty;

  assign wr_ptr_next = push ? wr_ptr + PTR_W'(1) : wr_ptr;
  assign rd_ptr_next = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign full_next   = (wr_ptr_next[IDX_W] != rd_ptr_next[IDX_W]) &&
                       (wr_ptr_next[IDX_W-1:0] == rd_ptr_next[IDX_W-1:0]);

  // Counts cycles in which a queued memory result was passed over by the ALU.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    starve_cnt_next = starve_cnt;
    if (empty || pop) begin
      starve_cnt_next = '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt_next = starve_cnt + CNT_W'(1);
    end
  end

  // Control state. alu_stall is registered from the next-state values, so it
  // is high exactly while the FIFO is full or its head has starved.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      starve_cnt <= starve_cnt_next;
      alu_stall  <= full_next || (starve_cnt_next == STARVE_MAX);
    end
  end

  // NOTE: FIFO storage is deliberately not reset; entry validity comes only
  // from the pointers, and leaving the array reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_idx]   <= mem_rd;
      fifo_data[wr_idx] <= mem_data;
    end
  end

  // Write stage: ALU first, otherwise the FIFO head. AD3/WD3 hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WE3 <= 1'b0;
      AD3 <= '0;
      WD3 <= '0;
    end else if (alu_take) begin
      WE3 <= 1'b1;
      AD3 <= alu_rd;
      WD3 <= alu_data;
    end else if (pop) begin
      WE3 <= 1'b1;
      AD3 <= fifo_rd[rd_idx];
      WD3 <= fifo_data[rd_idx];
    end else begin
      WE3 <= 1'b0;
    end
  end

`ifdef WB_PENDING_QUERY_EN
  logic [PTR_W-1:0] occupancy;
  assign occupancy = wr_ptr - rd_ptr;

  always_comb begin
    qry_hit = WE3 && (AD3 == qry_addr);
    for (int i = 0; i < DEPTH; i++) begin
      if ((PTR_W'(i) < occupancy) &&
          (fifo_rd[rd_idx + IDX_W'(i)] == qry_addr)) begin
        qry_hit = 1'b1;
      end
    end
    // x0 is never written, so it can never be pending.
    if (qry_addr == '0) begin
      qry_hit = 1'b0;
    end
  end
`else
  logic unused_qry;
  assign unused_qry = ^qry_addr;
  assign qry_hit    = 1'b0;
`endif

  // Upstream must hold off ALU results while stalled; such a result is lost.
  alu_valid_during_stall : assert property (
    @(posedge clk) disable iff (!rst_n) !(alu_valid && alu_stall)
  ) else $error("regfile_writeback: alu_valid asserted while alu_stall is high");

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  localparam int AW = 5;
  localparam int DW = 32;

`ifdef WB_PENDING_QUERY_EN
  localparam bit QRY_EN = 1'b1;
`else
  localparam bit QRY_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_data;
  logic          alu_stall;
  logic [AW-1:0] AD3;
  logic          WE3;
  logic [DW-1:0] WD3;
  logic [AW-1:0] qry_addr;
  logic          qry_hit;

  int checks   = 0;
  int failures = 0;

  regfile_writeback #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .DEPTH        (4),
    .STARVE_LIMIT (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_valid(alu_valid),
    .alu_rd   (alu_rd),
    .alu_data (alu_data),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .alu_stall(alu_stall),
    .AD3      (AD3),
    .WE3      (WE3),
    .WD3      (WD3),
    .qry_addr (qry_addr),
    .qry_hit  (qry_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    mem_valid = 1'b1;
    mem_rd    = 5'd5;
    mem_data  = 32'hDEAD;
    qry_addr  = '0;

    // Reset with mem_valid held high.
    #12;
    check("rst_we3",   WE3,       0);
    check("rst_ready", mem_ready, 1);
    check("rst_stall", alu_stall, 0);
    check("rst_ad3",   AD3,       0);
    check("rst_wd3",   WD3,       0);
    rst_n = 1'b1;

    // Memory path minimum latency: push, pop, then visible on the port.
    tick();
    mem_valid = 1'b0;
    check("mem_lat_we3_n1", WE3, 0);
    tick();
    check("mem_lat_we3", WE3, 1);
    check("mem_lat_ad3", AD3, 5);
    check("mem_lat_wd3", WD3, 32'hDEAD);
    tick();
    check("idle_we3",      WE3, 0);
    check("idle_ad3_hold", AD3, 5);
    check("idle_wd3_hold", WD3, 32'hDEAD);

    // Concurrent ALU and memory results: ALU first, memory next cycle.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h22;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("prio_alu_we3", WE3, 1);
    check("prio_alu_ad3", AD3, 3);
    check("prio_alu_wd3", WD3, 32'h11);
    tick();
    check("prio_mem_we3", WE3, 1);
    check("prio_mem_ad3", AD3, 7);
    check("prio_mem_wd3", WD3, 32'h22);
    tick();
    check("prio_idle_we3", WE3, 0);

    // x0 targets from both sources never assert WE3.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h66;
    #1;
    check("x0_ready", mem_ready, 1);
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("x0_we3_a", WE3, 0);
    tick();
    check("x0_we3_b", WE3, 0);

    // An ALU x0 result does not block a pop.
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
    tick();
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h77;
    check("x0pop_push_we3", WE3, 0);
    tick();
    alu_valid = 1'b0;
    check("x0pop_we3", WE3, 1);
    check("x0pop_ad3", AD3, 4);
    check("x0pop_wd3", WD3, 32'h44);
    tick();
    check("x0pop_idle_we3", WE3, 0);

    // Starvation: one entry under continuous ALU traffic.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100;
    mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hC;
    tick();
    mem_valid = 1'b0;
    check("starve_e0_ad3", AD3, 1);
    alu_rd = 5'd2; alu_data = 32'h200;
    tick();
    check("starve_e1_stall", alu_stall, 0);
    alu_rd = 5'd3; alu_data = 32'h300;
    tick();
    check("starve_e2_stall", alu_stall, 0);
    check("starve_e2_ad3",   AD3,       3);
    alu_rd = 5'd4; alu_data = 32'h400;
    tick();
    check("starve_e3_stall", alu_stall, 1);
    check("starve_e3_ad3",   AD3,       4);
    check("starve_e3_wd3",   WD3,       32'h400);
    alu_valid = 1'b0;
    tick();
    check("starve_pop_we3",   WE3,       1);
    check("starve_pop_ad3",   AD3,       12);
    check("starve_pop_wd3",   WD3,       32'hC);
    check("starve_pop_stall", alu_stall, 0);
    tick();
    check("starve_idle_we3", WE3, 0);

    // Fill the FIFO under ALU traffic, then drain in order.
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = AW'(i + 1); alu_data = 32'h1000 + 32'(i);
      mem_valid = 1'b1; mem_rd = AW'(8 + i); mem_data = 32'hA0 + 32'(i);
      tick();
      check("fill_ad3",   AD3,       32'(i + 1));
      check("fill_ready", mem_ready, (i == 3) ? 32'd0 : 32'd1);
    end
    check("fill_stall", alu_stall, 1);
    // Offer one more while full: must be refused.
    alu_valid = 1'b0;
    mem_rd = 5'd13; mem_data = 32'hBAD;
    tick();
    mem_valid = 1'b0;
    check("drain0_ad3",   AD3,       8);
    check("drain0_wd3",   WD3,       32'hA0);
    check("drain0_ready", mem_ready, 1);
    check("drain0_stall", alu_stall, 0);
    for (int j = 1; j < 4; j++) begin
      tick();
      check("drain_we3", WE3, 1);
      check("drain_ad3", AD3, 32'(8 + j));
      check("drain_wd3", WD3, 32'hA0 + 32'(j));
    end
    tick();
    check("drain_done_we3", WE3, 0);

    // Pending-write query.
    qry_addr = 5'd9;
    #1;
    check("qry_before", qry_hit, 0);
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    tick();
    mem_valid = 1'b0;
    check("qry_queued", qry_hit, QRY_EN ? 32'd1 : 32'd0);
    tick();
    check("qry_staged_ad3", AD3,     9);
    check("qry_staged",     qry_hit, QRY_EN ? 32'd1 : 32'd0);
    tick();
    check("qry_written", qry_hit, 0);

    // Reset mid-operation with three entries queued.
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_rd = AW'(k + 1); alu_data = 32'h2000 + 32'(k);
      mem_valid = 1'b1; mem_rd = AW'(20 + k); mem_data = 32'hB0 + 32'(k);
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    qry_addr = 5'd20;
    check("mid_we3_before", WE3, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_we3",   WE3,       0);
    check("mid_rst_ready", mem_ready, 1);
    check("mid_rst_stall", alu_stall, 0);
    check("mid_rst_ad3",   AD3,       0);
    check("mid_rst_qry",   qry_hit,   0);
    #2;
    rst_n = 1'b1;
    tick();
    check("mid_post_we3_a", WE3, 0);
    tick();
    check("mid_post_we3_b", WE3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
